// File: rtl/fifo_write_pointer_ctrl.sv
// fifo_write_pointer_ctrl
// Write-domain pointer and full-flag controller for an asynchronous FIFO.
// Keeps the binary write pointer (address plus wrap bit) and a registered Gray
// copy for the read-domain synchronizer. It gates client writes against the
// synchronized read pointer and flags writes that are dropped while full.
//
// Optional feature: define FIFO_WR_LEVEL_EN to add the registered occupancy
// (w_level) and almost-full (w_almost_full) outputs. This also adds the
// Gray-to-binary conversion of the read pointer that they need.

module fifo_write_pointer_ctrl #(
    parameter int ADDR_WIDTH         = 4,
    parameter int ALMOST_FULL_THRESH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_inc,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH:0]   w_ptr_bin,
    output logic [ADDR_WIDTH:0]   w_ptr_gray,
    output logic                  w_full,
    output logic                  w_overflow
`ifdef FIFO_WR_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   w_level,
    output logic                  w_almost_full
`endif
);

    localparam int PW  = ADDR_WIDTH + 1;
    localparam int MSB = ADDR_WIDTH;

    // The full test inverts the top two Gray bits, so the address needs at
    // least 2 bits. The almost-full threshold cannot exceed the depth.
    if (ADDR_WIDTH < 2) begin : g_bad_addr_width
        $error("fifo_write_pointer_ctrl: ADDR_WIDTH must be at least 2");
    end
    if (ALMOST_FULL_THRESH > (1 << ADDR_WIDTH)) begin : g_bad_thresh
        $error("fifo_write_pointer_ctrl: ALMOST_FULL_THRESH exceeds FIFO depth");
    end

    logic [PW-1:0] w_ptr_bin_q,  w_ptr_bin_d;
    logic [PW-1:0] w_ptr_gray_q, w_ptr_gray_d;
    logic          w_full_q,     w_full_d;
    logic          w_overflow_q, w_overflow_d;
    logic [PW-1:0] rd_full_cmp;

    // The write strobe uses the registered full flag, so the read pointer has
    // no combinational path to any output.
    assign w_en = w_inc & ~w_full_q;

    // Next-pointer, Gray encoding, full and overflow evaluation
    always_comb begin
        // NOTE: every always_comb output gets a default on entry so that no
        // path through the block can leave it unassigned and infer a latch.
        w_ptr_bin_d  = w_ptr_bin_q + {{ADDR_WIDTH{1'b0}}, w_en};
        w_ptr_gray_d = w_ptr_bin_d ^ (w_ptr_bin_d >> 1);
        // The FIFO is full when the write pointer is exactly one lap ahead of
        // the read pointer. In Gray code, that means the top two bits differ
        // and the rest are equal.
        rd_full_cmp  = {~rd_ptr_gray_sync[MSB:MSB-1], rd_ptr_gray_sync[MSB-2:0]};
        w_full_d     = (w_ptr_gray_d == rd_full_cmp);
        w_overflow_d = w_inc & w_full_q;
    end

    // Pointer, Gray copy, full and overflow registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples its pre-edge value; blocking assignments here would
        // create order-dependent races between registers.
        if (rst) begin
            w_ptr_bin_q  <= '0;
            w_ptr_gray_q <= '0;
            w_full_q     <= 1'b0;
            w_overflow_q <= 1'b0;
        end else begin
            w_ptr_bin_q  <= w_ptr_bin_d;
            w_ptr_gray_q <= w_ptr_gray_d;
            w_full_q     <= w_full_d;
            w_overflow_q <= w_overflow_d;
        end
    end

    assign w_addr     = w_ptr_bin_q[ADDR_WIDTH-1:0];
    assign w_ptr_bin  = w_ptr_bin_q;
    assign w_ptr_gray = w_ptr_gray_q;
    assign w_full     = w_full_q;
    assign w_overflow = w_overflow_q;

`ifdef FIFO_WR_LEVEL_EN
    localparam logic [PW-1:0] AF_THRESH = PW'(ALMOST_FULL_THRESH);

    logic [PW-1:0] rd_ptr_bin;
    logic [PW-1:0] w_level_q, w_level_d;
    logic          w_almost_full_q, w_almost_full_d;

    // Gray-to-binary conversion of the read pointer and occupancy evaluation
    always_comb begin
        rd_ptr_bin      = '0;
        rd_ptr_bin[MSB] = rd_ptr_gray_sync[MSB];
        for (int i = MSB - 1; i >= 0; i--) begin
            rd_ptr_bin[i] = rd_ptr_bin[i+1] ^ rd_ptr_gray_sync[i];
        end
        // Pointers carry a wrap bit, so the modular difference covers the
        // full range 0..depth.
        w_level_d       = w_ptr_bin_d - rd_ptr_bin;
        w_almost_full_d = (w_level_d >= AF_THRESH);
    end

    // Occupancy and almost-full registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            w_level_q       <= '0;
            w_almost_full_q <= 1'b0;
        end else begin
            w_level_q       <= w_level_d;
            w_almost_full_q <= w_almost_full_d;
        end
    end

    assign w_level       = w_level_q;
    assign w_almost_full = w_almost_full_q;
`endif

endmodule

// File: tb/tb_fifo_write_pointer_ctrl.sv
// Directed testbench for fifo_write_pointer_ctrl (default ADDR_WIDTH = 4).
// Level / almost-full checks are compiled in only when FIFO_WR_LEVEL_EN is defined.

module tb_fifo_write_pointer_ctrl;

    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          w_inc;
    logic [AW:0]   rd_ptr_gray_sync;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [AW:0]   w_ptr_bin;
    logic [AW:0]   w_ptr_gray;
    logic          w_full;
    logic          w_overflow;
`ifdef FIFO_WR_LEVEL_EN
    logic [AW:0]   w_level;
    logic          w_almost_full;
`endif

    int vectors     = 0;
    int miscompares = 0;

    fifo_write_pointer_ctrl #(
        .ADDR_WIDTH         (AW),
        .ALMOST_FULL_THRESH (14)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .w_inc            (w_inc),
        .rd_ptr_gray_sync (rd_ptr_gray_sync),
        .w_en             (w_en),
        .w_addr           (w_addr),
        .w_ptr_bin        (w_ptr_bin),
        .w_ptr_gray       (w_ptr_gray),
        .w_full           (w_full),
        .w_overflow       (w_overflow)
`ifdef FIFO_WR_LEVEL_EN
        ,
        .w_level          (w_level),
        .w_almost_full    (w_almost_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW:0] to_gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW:0] p;
        logic [AW:0] prev_gray;

        rst              = 1'b1;
        w_inc            = 1'b0;
        rd_ptr_gray_sync = '0;
        tick();

        // Reset state
        check("rst_bin",  32'(w_ptr_bin),  32'd0);
        check("rst_gray", 32'(w_ptr_gray), 32'd0);
        check("rst_full", 32'(w_full),     32'd0);
        check("rst_ovf",  32'(w_overflow), 32'd0);

        // w_en follows w_inc during reset, but the pointer must not advance
        w_inc = 1'b1;
        #1;
        check("rst_wen", 32'(w_en), 32'd1);
        tick();
        check("rst_hold_bin", 32'(w_ptr_bin), 32'd0);
        rst = 1'b0;

        // Fill: 16 writes with the reader parked at 0
        for (int i = 0; i < 16; i++) begin
            w_inc = 1'b1;
            #1;
            check("fill_addr", 32'(w_addr), 32'(i));
            check("fill_wen",  32'(w_en),   32'd1);
            check("fill_full_before", 32'(w_full), 32'd0);
            tick();
        end
        check("full_bin",  32'(w_ptr_bin),  32'd16);
        check("full_gray", 32'(w_ptr_gray), 32'b11000);
        check("full_flag", 32'(w_full),     32'd1);

        // Writes while full are dropped and flagged as overflow
        for (int i = 0; i < 2; i++) begin
            w_inc = 1'b1;
            #1;
            check("ovf_wen", 32'(w_en), 32'd0);
            tick();
            check("ovf_pulse", 32'(w_overflow), 32'd1);
            check("ovf_bin",   32'(w_ptr_bin),  32'd16);
        end
        w_inc = 1'b0;
        tick();
        check("ovf_clear", 32'(w_overflow), 32'd0);
        check("ovf_still_full", 32'(w_full), 32'd1);

        // Reader advances by one: full drops, and one write refills
        rd_ptr_gray_sync = 5'b00001;
        tick();
        check("rd_adv_full", 32'(w_full), 32'd0);
        w_inc = 1'b1;
        #1;
        check("refill_wen", 32'(w_en), 32'd1);
        tick();
        check("refill_bin",  32'(w_ptr_bin),  32'd17);
        check("refill_gray", 32'(w_ptr_gray), 32'b11001);
        check("refill_full", 32'(w_full),     32'd1);
        w_inc = 1'b0;

        // Wrap: the reader trails the writer, so the FIFO never fills
        rd_ptr_gray_sync = to_gray(5'd15);
        tick();
        check("wrap_start_full", 32'(w_full), 32'd0);
        p = 5'd17;
        for (int i = 0; i < 20; i++) begin
            rd_ptr_gray_sync = to_gray(p - 5'd1);
            w_inc            = 1'b1;
            prev_gray        = w_ptr_gray;
            #1;
            check("wrap_wen", 32'(w_en), 32'd1);
            tick();
            p = p + 5'd1;
            check("wrap_bin",   32'(w_ptr_bin),  32'(p));
            check("wrap_gray",  32'(w_ptr_gray), 32'(to_gray(p)));
            check("wrap_full",  32'(w_full),     32'd0);
            check("wrap_1bit",  32'($countones(prev_gray ^ w_ptr_gray)), 32'd1);
            if (p == 5'd0) begin
                check("wrap_gray_prev", 32'(prev_gray), 32'b10000);
            end
        end
        w_inc            = 1'b0;
        rd_ptr_gray_sync = '0;

        // Reset in mid-operation at pointer 9, with w_inc still high
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            w_inc = 1'b1;
            tick();
        end
        check("pre_rst_bin", 32'(w_ptr_bin), 32'd9);
        rst = 1'b1;
        tick();
        check("midrst_bin",  32'(w_ptr_bin),  32'd0);
        check("midrst_addr", 32'(w_addr),     32'd0);
        check("midrst_gray", 32'(w_ptr_gray), 32'd0);
        check("midrst_full", 32'(w_full),     32'd0);
        check("midrst_ovf",  32'(w_overflow), 32'd0);
        rst   = 1'b0;
        w_inc = 1'b0;
        tick();

`ifdef FIFO_WR_LEVEL_EN
        // Occupancy and almost-full flag
        check("lvl_rst", 32'(w_level), 32'd0);
        for (int i = 0; i < 14; i++) begin
            w_inc = 1'b1;
            tick();
            if (i == 12) begin
                check("lvl_13",    32'(w_level),       32'd13);
                check("lvl_af_13", 32'(w_almost_full), 32'd0);
            end
        end
        w_inc = 1'b0;
        check("lvl_14",    32'(w_level),       32'd14);
        check("lvl_af_14", 32'(w_almost_full), 32'd1);
        rd_ptr_gray_sync = 5'b00011;
        tick();
        check("lvl_12",    32'(w_level),       32'd12);
        check("lvl_af_12", 32'(w_almost_full), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_write_pointer_ctrl.md
# fifo_write_pointer_ctrl

Write-domain pointer and full-flag controller for the asynchronous FIFO. Maintains the binary write pointer (address plus wrap bit), qualifies write requests against the synchronized read pointer, and drives the binary pointer into the Gray encoder stage. It also produces a registered Gray copy for clock-domain crossing. Sits between the write-side client and the write-pointer Gray encoder / read-domain synchronizer.

## Interface
- ADDR_WIDTH, 4: memory address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
- ALMOST_FULL_THRESH, 14: occupancy at or above which w_almost_full asserts (only with FIFO_WR_LEVEL_EN)

Ports:
- clk  in  1  write-domain clock; single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- w_inc  in  1  write request from client
- rd_ptr_gray_sync  in  ADDR_WIDTH+1  read pointer, Gray coded, already synchronized into clk domain
- w_en  out  1  memory write strobe = w_inc & ~w_full (combinational)
- w_addr  out  ADDR_WIDTH  memory write address = w_ptr_bin[ADDR_WIDTH-1:0]
- w_ptr_bin  out  ADDR_WIDTH+1  registered binary write pointer, feeds Gray encoder
- w_ptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, for the synchronizer
- w_full  out  1  registered full flag
- w_overflow  out  1  registered one-cycle pulse: previous cycle had w_inc while w_full
- w_level  out  ADDR_WIDTH+1  registered occupancy (FIFO_WR_LEVEL_EN only)
- w_almost_full  out  1  registered (FIFO_WR_LEVEL_EN only)

## Operation
- Reset: w_ptr_bin=0, w_ptr_gray=0, w_full=0, w_overflow=0, w_level=0, w_almost_full=0; w_en=0 only because w_inc gated by full=0 → w_en follows w_inc during reset but pointer does not advance.
- bin_next = w_ptr_bin + (w_inc & ~w_full), modulo 2^(ADDR_WIDTH+1); wrap 31→0 at default width.
- gray_next = bin_next ^ (bin_next >> 1); registered into w_ptr_gray same edge as bin_next into w_ptr_bin (both bits-consistent every cycle; at most one Gray bit changes per cycle).
- Full: full_next = (gray_next == {~rd_ptr_gray_sync[MSB:MSB-1], rd_ptr_gray_sync[MSB-2:0]}).
- Writes while full are dropped: pointer holds, w_en=0, w_overflow pulses next cycle.
- Full deasserts only via rd_ptr_gray_sync advancing; pessimistic by synchronizer latency, never optimistic.
- No state machine beyond pointer register; no handshake beyond w_inc/w_full.
- Reset mid-operation: all registers return to reset values on next edge regardless of w_inc.

## Timing
- Latency: w_inc sampled at edge N → w_ptr_bin/w_ptr_gray/w_full updated at edge N (visible cycle N+1).
- w_full asserts the cycle after the write that fills the FIFO; no write can be accepted in that cycle since w_en is gated by registered w_full — full computed from gray_next prevents the extra write.
- w_en is combinational from w_inc and registered w_full; no combinational path from rd_ptr_gray_sync to any output.
- rd_ptr_gray_sync change and w_inc in same cycle: full_next evaluated on both new values.

## Configuration
- FIFO_WR_LEVEL_EN defined: Gray-to-binary conversion of rd_ptr_gray_sync (rbin[i] = XOR of gray bits i..MSB); w_level registered = bin_next − rbin (mod 2^(ADDR_WIDTH+1), range 0..2^ADDR_WIDTH); w_almost_full registered = (level_next >= ALMOST_FULL_THRESH).
- Undefined: w_level and w_almost_full ports absent, no conversion logic.

## Test plan
- Reset then 16 consecutive w_inc with rd_ptr_gray_sync=0 → w_addr 0..15, w_full=1 after 16th write, w_ptr_bin=16, w_ptr_gray=5'b11000.
- While full, w_inc=1 for 2 cycles → w_en=0, pointer stays 16, w_overflow high for 2 cycles, then 0.
- From full, set rd_ptr_gray_sync=5'b00001 → w_full=0 next edge; one write accepted, w_full=1 again.
- Wrap: continuous writes with reader tracking (rd = wr−2 Gray) across 31→0 → w_ptr_bin wraps to 0, w_ptr_gray 5'b10000→5'b00000, single-bit Gray change every cycle, no spurious w_full.
- Assert rst with w_inc=1 at pointer 9 → next cycle all outputs at reset values, pointer 0.
- FIFO_WR_LEVEL_EN: 14 writes, rd=0 → w_level=14, w_almost_full=1; rd_ptr_gray_sync=5'b00011 (bin 2) → w_level=12, w_almost_full=0.
